// File: rtl/data_memory_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Types and constants shared by the data-memory stage and its wait counter.
//   mem_state_t       : access FSM states (IDLE -> BUSY -> DONE -> IDLE)
//   WORD_OFFSET_BITS  : byte-offset bits below the word index in a byte address
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int WORD_OFFSET_BITS = 2;

endpackage

// File: rtl/data_memory_ctrl_wait_counter.sv
// -----------------------------------------------------------------------------
// mem_wait_counter
// 4-bit down counter that paces memory wait states.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset, clears count to 0
//   load_i     in   load load_val_i (has priority over dec_i)
//   load_val_i in   value to load
//   dec_i      in   decrement by one (saturates at 0)
//   count_o    out  current count
//   zero_o     out  count is zero
// -----------------------------------------------------------------------------
module mem_wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic [3:0] count_o,
    output logic       zero_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == 4'd0);

endmodule

// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
// Data-memory stage after the ALU: word load/store into an internal array with
// a configurable number of wait states. Misaligned accesses are flagged and
// not performed.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset (array contents kept)
//   ALUResult  in   byte address
//   WriteData  in   store data
//   MemWrite   in   store request (wins over MemRead)
//   MemRead    in   load request
//   ReadData   out  registered load result, held until the next load
//   Stall      out  hold PC/pipeline while an access is in flight
//   MemDone    out  one-cycle pulse in the completing cycle
//   AddrError  out  pulse with MemDone when the access was misaligned
// -----------------------------------------------------------------------------
module data_memory_ctrl
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Stall,
    output logic                  MemDone,
    output logic                  AddrError
);

    localparam int         IDX_W    = $clog2(MEM_DEPTH);
    // Counter starts one below the wait-state count: the BUSY cycle that sees
    // zero is itself the last wait state.
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    mem_state_t              state_q, state_d;
    logic [IDX_W-1:0]        idx_q;
    logic                    mis_q;
    logic                    store_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic                    req;
    logic                    capture;
    logic                    cnt_zero;
    logic [3:0]              cnt_val;

    assign req     = MemRead | MemWrite;
    assign capture = (state_q == IDLE) && req;

    mem_wait_counter u_wait_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (capture),
        .load_val_i (CNT_INIT),
        .dec_i      (state_q == BUSY),
        .count_o    (cnt_val),
        .zero_o     (cnt_zero)
    );

    // Address bits above the word index wrap the array and are not decoded.
    if (DATA_WIDTH > IDX_W + WORD_OFFSET_BITS) begin : g_addr_hi
        logic addr_hi_unused;
        assign addr_hi_unused = ^ALUResult[DATA_WIDTH-1:IDX_W+WORD_OFFSET_BITS];
    end
    logic cnt_val_unused;
    assign cnt_val_unused = ^cnt_val;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req) state_d = (WAIT_STATES == 0) ? DONE : BUSY;
            BUSY: if (cnt_zero) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request is latched once in IDLE; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (capture) begin
            idx_q   <= ALUResult[IDX_W+WORD_OFFSET_BITS-1:WORD_OFFSET_BITS];
            mis_q   <= |ALUResult[WORD_OFFSET_BITS-1:0];
            store_q <= MemWrite;
            wdata_q <= WriteData;
        end
    end

    // Reset in the DONE cycle drops a store that has not committed yet.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == DONE) && store_q && !mis_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else if ((state_q == DONE) && !store_q && !mis_q) begin
            rdata_q <= mem_q[idx_q];
        end
    end

    assign ReadData  = rdata_q;
    assign Stall     = capture || (state_q == BUSY);
    assign MemDone   = (state_q == DONE);
    assign AddrError = (state_q == DONE) && mis_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: WAIT_STATES=2, instance 1: WAIT_STATES=0
    logic        rst_s   [2];
    logic [31:0] alu_s   [2];
    logic [31:0] wd_s    [2];
    logic        mw_s    [2];
    logic        mr_s    [2];
    logic [31:0] rd_s    [2];
    logic        stall_s [2];
    logic        done_s  [2];
    logic        aerr_s  [2];

    data_memory_ctrl #(.DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(2)) u_dut0 (
        .clk(clk), .reset(rst_s[0]), .ALUResult(alu_s[0]), .WriteData(wd_s[0]),
        .MemWrite(mw_s[0]), .MemRead(mr_s[0]), .ReadData(rd_s[0]),
        .Stall(stall_s[0]), .MemDone(done_s[0]), .AddrError(aerr_s[0]));

    data_memory_ctrl #(.DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(0)) u_dut1 (
        .clk(clk), .reset(rst_s[1]), .ALUResult(alu_s[1]), .WriteData(wd_s[1]),
        .MemWrite(mw_s[1]), .MemRead(mr_s[1]), .ReadData(rd_s[1]),
        .Stall(stall_s[1]), .MemDone(done_s[1]), .AddrError(aerr_s[1]));

    // Reference model: word memory with written-flags, expected ReadData.
    int          ws_of [2] = '{2, 0};
    logic [31:0] mem_m [2][64];
    bit          val_m [2][64];
    logic [31:0] rd_m  [2];
    bit          rdk_m [2];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_commit(input int k, input logic [31:0] a, input logic [31:0] d, input bit we);
        int idx;
        idx = int'((a >> 2) % 64);
        if (a % 4 != 0) return;
        if (we) begin
            mem_m[k][idx] = d;
            val_m[k][idx] = 1'b1;
        end else begin
            rd_m[k]  = mem_m[k][idx];
            rdk_m[k] = val_m[k][idx];
        end
    endtask

    // One complete access: checks ReadData left by the previous access, then
    // the Stall/MemDone/AddrError timing over WAIT_STATES+2 cycles.
    task automatic access(input int k, input logic [31:0] a, input logic [31:0] d,
                          input bit we, input bit re, input bit scramble);
        bit mis;
        mis = (a % 4 != 0);
        @(negedge clk);
        if (rdk_m[k]) chk($sformatf("rdata%0d", k), rd_s[k], rd_m[k]);
        alu_s[k] = a; wd_s[k] = d; mw_s[k] = we; mr_s[k] = re;
        #1;
        chk($sformatf("stall_cap%0d", k), 32'(stall_s[k]), 32'd1);
        chk($sformatf("done_cap%0d", k), 32'(done_s[k]), 32'd0);
        for (int c = 1; c <= ws_of[k]; c++) begin
            @(negedge clk);
            if (scramble) begin
                alu_s[k] = $urandom; wd_s[k] = $urandom;
                mw_s[k] = 1'($urandom); mr_s[k] = 1'($urandom);
            end
            #1;
            chk($sformatf("stall_busy%0d", k), 32'(stall_s[k]), 32'd1);
            chk($sformatf("done_busy%0d", k), 32'(done_s[k]), 32'd0);
            chk($sformatf("aerr_busy%0d", k), 32'(aerr_s[k]), 32'd0);
        end
        @(negedge clk);
        alu_s[k] = '0; wd_s[k] = '0; mw_s[k] = 1'b0; mr_s[k] = 1'b0;
        #1;
        chk($sformatf("stall_done%0d", k), 32'(stall_s[k]), 32'd0);
        chk($sformatf("memdone%0d", k), 32'(done_s[k]), 32'd1);
        chk($sformatf("aerr_done%0d", k), 32'(aerr_s[k]), 32'(mis));
        model_commit(k, a, d, we);
    endtask

    task automatic idle_check(input int k);
        @(negedge clk);
        #1;
        chk($sformatf("idle_stall%0d", k), 32'(stall_s[k]), 32'd0);
        chk($sformatf("idle_done%0d", k), 32'(done_s[k]), 32'd0);
        chk($sformatf("idle_aerr%0d", k), 32'(aerr_s[k]), 32'd0);
        if (rdk_m[k]) chk($sformatf("idle_rdata%0d", k), rd_s[k], rd_m[k]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        bit          we;
        for (int k = 0; k < 2; k++) begin
            rst_s[k] = 1'b1; alu_s[k] = '0; wd_s[k] = '0; mw_s[k] = 1'b0; mr_s[k] = 1'b1;
            rd_m[k] = '0; rdk_m[k] = 1'b1;
            for (int i = 0; i < 64; i++) val_m[k][i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            rst_s[k] = 1'b0; mr_s[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_stall%0d", k), 32'(stall_s[k]), 32'd0);
            chk($sformatf("rst_done%0d", k), 32'(done_s[k]), 32'd0);
            chk($sformatf("rst_aerr%0d", k), 32'(aerr_s[k]), 32'd0);
            chk($sformatf("rst_rdata%0d", k), rd_s[k], 32'd0);
        end

        // Directed, WAIT_STATES=2
        access(0, 32'h10,  32'hDEADBEEF, 1, 0, 0);
        access(0, 32'h10,  32'h0,        0, 1, 0);
        access(0, 32'h100, 32'h12345678, 1, 0, 0);
        access(0, 32'h000, 32'h0,        0, 1, 0);
        access(0, 32'h13,  32'h0,        0, 1, 0);
        access(0, 32'h12,  32'hCAFEF00D, 1, 0, 0);
        access(0, 32'h10,  32'h0,        0, 1, 0);
        access(0, 32'h20,  32'hA5A5A5A5, 1, 1, 1);
        access(0, 32'h20,  32'h0,        0, 1, 0);
        idle_check(0);
        idle_check(0);

        // Reset while BUSY drops a pending store of 0x55 at 0x8
        access(0, 32'h8, 32'h11111111, 1, 0, 0);
        @(negedge clk);
        chk("rdata_pre_rst", rd_s[0], rd_m[0]);
        alu_s[0] = 32'h8; wd_s[0] = 32'h55; mw_s[0] = 1'b1; mr_s[0] = 1'b0;
        @(negedge clk);
        rst_s[0] = 1'b1; alu_s[0] = '0; wd_s[0] = '0; mw_s[0] = 1'b0;
        @(negedge clk);
        rst_s[0] = 1'b0;
        rd_m[0] = '0; rdk_m[0] = 1'b1;
        #1;
        chk("rstbusy_stall", 32'(stall_s[0]), 32'd0);
        chk("rstbusy_done", 32'(done_s[0]), 32'd0);
        chk("rstbusy_rdata", rd_s[0], 32'd0);
        access(0, 32'h8, 32'h0, 0, 1, 0);
        idle_check(0);

        // WAIT_STATES=0: back-to-back accesses of 2 cycles each
        access(1, 32'h40, 32'h0BADF00D, 1, 0, 0);
        access(1, 32'h44, 32'h76543210, 1, 0, 0);
        access(1, 32'h40, 32'h0,        0, 1, 0);
        access(1, 32'h44, 32'h0,        0, 1, 0);
        access(1, 32'h41, 32'h0,        0, 1, 0);
        access(1, 32'h140, 32'h0,       0, 1, 0);
        idle_check(1);

        // Randomized traffic on both instances
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < 2; k++) begin
                a  = {$urandom_range(0, 3) == 0 ? 24'($urandom) : 24'h0, 8'($urandom_range(0, 63))};
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                we = 1'($urandom);
                access(k, a, $urandom, we, we ? 1'($urandom) : 1'b1, 1'($urandom));
            end
        end
        idle_check(0);
        idle_check(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
